// File: rtl/riscv_lsu.sv
// Load/store unit: one handshaked bus transaction per load/store, with store lane
// replication, byte enables, load alignment/extension, misalign and timeout detection.
module riscv_lsu #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_wr_en,
  input  logic [3:0]  i_lsu_byte_sel,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_stall,
  output logic        o_lsu_done,
  output logic        o_lsu_misalign,
  output logic        o_lsu_err,
  output logic        o_lsu_bus_req,
  output logic        o_lsu_bus_we,
  output logic [31:0] o_lsu_bus_addr,
  output logic [3:0]  o_lsu_bus_be,
  output logic [31:0] o_lsu_bus_wdata,
  input  logic        i_lsu_bus_ack,
  input  logic [31:0] i_lsu_bus_rdata
);
  // state  | meaning
  // S_IDLE | waiting for a load/store; decides aligned vs misaligned
  // S_REQ  | bus request outstanding, counting cycles toward timeout
  // S_DONE | one-cycle completion pulse, core advances on this edge
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_misalign;
  logic        r_err;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_ldata;

  assign w_misalign = ((i_lsu_byte_sel == 4'b0011) && i_lsu_addr[0]) ||
                      ((i_lsu_byte_sel == 4'b1111) && (i_lsu_addr[1:0] != 2'b00));
  assign w_be = 4'(i_lsu_byte_sel << i_lsu_addr[1:0]);

  always_comb begin
    w_wdata = i_lsu_wdata;
    case (i_lsu_byte_sel)
      4'b0001: w_wdata = {4{i_lsu_wdata[7:0]}};
      4'b0011: w_wdata = {2{i_lsu_wdata[15:0]}};
      default: w_wdata = i_lsu_wdata;
    endcase
  end

  // Alignment uses the offset/funct3 latched at request time, not the live inputs.
  assign w_shift = i_lsu_bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ldata = w_shift;
    case (r_funct3)
      3'b000:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ldata = {24'b0, w_shift[7:0]};
      3'b101:  w_ldata = {16'b0, w_shift[15:0]};
      default: w_ldata = w_shift;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_off      <= 2'd0;
      r_funct3   <= 3'd0;
      r_rdata    <= 32'd0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_lsu_valid) begin
            if (w_misalign) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              r_rdata    <= 32'd0;
            end else begin
              r_state  <= S_REQ;
              r_req    <= 1'b1;
              r_we     <= i_lsu_wr_en;
              r_addr   <= {i_lsu_addr[31:2], 2'b00};
              r_be     <= w_be;
              r_wdata  <= w_wdata;
              r_off    <= i_lsu_addr[1:0];
              r_funct3 <= i_lsu_funct3;
              r_cnt    <= 8'd0;
            end
          end
        end
        S_REQ: begin
          if (i_lsu_bus_ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            if (!r_we) r_rdata <= w_ldata;
          end else if (r_cnt == 8'(BUS_TIMEOUT - 1)) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lsu_stall     = i_lsu_valid && !r_done;
  assign o_lsu_done      = r_done;
  assign o_lsu_misalign  = r_misalign;
  assign o_lsu_err       = r_err;
  assign o_lsu_rdata     = r_rdata;
  assign o_lsu_bus_req   = r_req;
  assign o_lsu_bus_we    = r_we;
  assign o_lsu_bus_addr  = r_addr;
  assign o_lsu_bus_be    = r_be;
  assign o_lsu_bus_wdata = r_wdata;
endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: directed loads/stores push expected bus and completion
// records; a negedge monitor pops and compares whenever req rises or done pulses.
module tb_riscv_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ack = 1'b0;
  logic [31:0] brdata = 32'd0;

  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic        o_stall, o_done, o_mis, o_err, o_req, o_we;
  logic [3:0]  o_be;

  always #5 clk = ~clk;

  riscv_lsu #(.BUS_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_lsu_valid(valid), .i_lsu_wr_en(we),
    .i_lsu_byte_sel(sel), .i_lsu_funct3(f3), .i_lsu_addr(addr), .i_lsu_wdata(wdata),
    .o_lsu_rdata(o_rdata), .o_lsu_stall(o_stall), .o_lsu_done(o_done),
    .o_lsu_misalign(o_mis), .o_lsu_err(o_err), .o_lsu_bus_req(o_req),
    .o_lsu_bus_we(o_we), .o_lsu_bus_addr(o_bus_addr), .o_lsu_bus_be(o_be),
    .o_lsu_bus_wdata(o_bus_wdata), .i_lsu_bus_ack(ack), .i_lsu_bus_rdata(brdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          lat;
    int          reqc;
    int          issue;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: bus fields checked on every req cycle, completion records on done.
  bus_t  cur_bus;
  done_t cur_done;
  int    reqc = 0;
  logic  prev_req = 1'b0;

  always @(negedge clk) begin
    chk("stall", {31'b0, o_stall}, {31'b0, valid && !o_done});
    if (rst) begin
      reqc     = 0;
      prev_req = 1'b0;
    end else begin
      if (o_req) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_req: got req=1 expected no request (cycle %0d)", cyc);
          end else begin
            cur_bus = bus_q.pop_front();
          end
        end
        reqc++;
        chk("bus_addr", o_bus_addr, cur_bus.addr);
        chk("bus_be", {28'b0, o_be}, {28'b0, cur_bus.be});
        chk("bus_we", {31'b0, o_we}, {31'b0, cur_bus.we});
        chk("bus_wdata", o_bus_wdata, cur_bus.wdata);
      end
      prev_req = o_req;
      if (o_done) begin
        if (done_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
        end else begin
          cur_done = done_q.pop_front();
          chk("rdata", o_rdata, cur_done.rdata);
          chk("misalign", {31'b0, o_mis}, {31'b0, cur_done.mis});
          chk("err", {31'b0, o_err}, {31'b0, cur_done.err});
          chk("latency", cyc - cur_done.issue, cur_done.lat);
          chk("req_cycles", reqc, cur_done.reqc);
        end
        reqc = 0;
      end
    end
  end

  // Issue one access in the cycle after a rising edge; k<0 means the bus never acks.
  task automatic access(input logic w, input logic [3:0] s, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int k, input logic [31:0] e_rd, input logic e_mis,
                        input logic e_err, input logic [3:0] e_be, input logic [31:0] e_wd,
                        input int e_lat, input int e_reqc);
    done_t d;
    bus_t  b;
    bit    got;
    d.rdata = e_rd; d.mis = e_mis; d.err = e_err;
    d.lat = e_lat; d.reqc = e_reqc; d.issue = cyc;
    done_q.push_back(d);
    if (!e_mis) begin
      b.addr = {a[31:2], 2'b00}; b.be = e_be; b.we = w; b.wdata = e_wd;
      bus_q.push_back(b);
    end
    we = w; sel = s; f3 = f; addr = a; wdata = wd; valid = 1'b1;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      // Scramble the request inputs after they were sampled; the transaction must not care.
      addr = ~a; f3 = ~f; wdata = ~wd; sel = ~s;
      ack = (k >= 0) && (c == k + 1);
      brdata = ack ? rd : 32'h0BAD_F00D;
      if (o_done) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_wait: got no done expected done within 20 cycles (addr 0x%08h)", a);
    end
    @(posedge clk); #1;
    valid = 1'b0; ack = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, o_req}, 32'd0);
    chk({tag, "_we"}, {31'b0, o_we}, 32'd0);
    chk({tag, "_addr"}, o_bus_addr, 32'd0);
    chk({tag, "_be"}, {28'b0, o_be}, 32'd0);
    chk({tag, "_wdata"}, o_bus_wdata, 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_done"}, {31'b0, o_done}, 32'd0);
    chk({tag, "_misalign"}, {31'b0, o_mis}, 32'd0);
    chk({tag, "_err"}, {31'b0, o_err}, 32'd0);
  endtask

  initial begin
    bus_t b;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_stall", {31'b0, o_stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //     we    sel      f3      addr          wdata         bus rdata     k   exp rdata     mis   err   be       bus wdata     lat rc
    access(1'b0, 4'b1111, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0,        4, 3);
    access(1'b0, 4'b0001, 3'b000, 32'h0000_0203, 32'h0,        32'h8012_3456, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b1000, 32'h0,        2, 1);
    access(1'b0, 4'b0001, 3'b100, 32'h0000_0203, 32'h0,        32'h8012_3456, 0, 32'h0000_0080, 1'b0, 1'b0, 4'b1000, 32'h0,        2, 1);
    access(1'b0, 4'b0011, 3'b101, 32'h0000_0202, 32'h0,        32'hBEEF_0000, 1, 32'h0000_BEEF, 1'b0, 1'b0, 4'b1100, 32'h0,        3, 2);
    access(1'b1, 4'b0001, 3'b000, 32'h0000_0302, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 32'h0000_BEEF, 1'b0, 1'b0, 4'b0100, 32'hA5A5_A5A5, 2, 1);
    access(1'b1, 4'b0011, 3'b001, 32'h0000_0302, 32'h0000_1234, 32'hFFFF_FFFF, 1, 32'h0000_BEEF, 1'b0, 1'b0, 4'b1100, 32'h1234_1234, 3, 2);
    access(1'b0, 4'b1111, 3'b010, 32'h0000_0102, 32'h0,        32'h1111_1111, 0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1, 0);
    access(1'b0, 4'b0011, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_0000, 0, 32'hFFFF_8001, 1'b0, 1'b0, 4'b1100, 32'h0,        2, 1);
    access(1'b0, 4'b0011, 3'b001, 32'h0000_0101, 32'h0,        32'h1111_1111, 0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1, 0);
    access(1'b0, 4'b0001, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 32'h0000_007F, 1'b0, 1'b0, 4'b0010, 32'h0,        2, 1);
    access(1'b0, 4'b1111, 3'b010, 32'h0000_0400, 32'h0,        32'h0,        -1, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h0,        5, 4);
    access(1'b0, 4'b1111, 3'b010, 32'h0000_0404, 32'h0,        32'h1234_5678, 3, 32'h1234_5678, 1'b0, 1'b0, 4'b1111, 32'h0,        5, 4);
    access(1'b1, 4'b1111, 3'b010, 32'h0000_0500, 32'hCAFE_BABE, 32'h0,       -1, 32'h0,        1'b0, 1'b1, 4'b1111, 32'hCAFE_BABE, 5, 4);

    // Reset in the middle of a request, then a stray ack while idle.
    b.addr = 32'h0000_0600; b.be = 4'b1111; b.we = 1'b0; b.wdata = 32'h0;
    bus_q.push_back(b);
    we = 1'b0; sel = 4'b1111; f3 = 3'b010; addr = 32'h0000_0600; wdata = 32'h0; valid = 1'b1;
    @(posedge clk); #1;
    chk("midreq_req", {31'b0, o_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("midreset");
    valid = 1'b0; rst = 1'b0;
    ack = 1'b1; brdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("stray_ack_done", {31'b0, o_done}, 32'd0);
    chk("stray_ack_req", {31'b0, o_req}, 32'd0);
    @(posedge clk); #1;
    chk("stray_ack_done2", {31'b0, o_done}, 32'd0);
    chk("stray_ack_rdata", o_rdata, 32'd0);

    access(1'b0, 4'b1111, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b1111, 32'h0,        2, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("done_q_empty", done_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion before 100000 time units");
    $fatal(1, "watchdog");
  end
endmodule
